// File: rtl/shift_pkg.sv
// Shared opcode encodings and FSM state type for the iterative shift unit.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLA = 2'b00,
    OP_SRA = 2'b01,
    OP_SRL = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift of a WIDTH vector selected by opcode.
// Rotate-right is only built when SHIFT_UNIT_ROTATE_EN is defined; otherwise it passes data through.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_d,
  input  op_e              i_op,
  output logic [WIDTH-1:0] o_q
);

  always_comb begin
    o_q = i_d;
    case (i_op)
      OP_SLA:  o_q = {i_d[WIDTH-2:0], 1'b0};
      OP_SRA:  o_q = {i_d[WIDTH-1], i_d[WIDTH-1:1]};
      OP_SRL:  o_q = {1'b0, i_d[WIDTH-1:1]};
`ifdef SHIFT_UNIT_ROTATE_EN
      OP_ROR:  o_q = {i_d[0], i_d[WIDTH-1:1]};
`endif
      default: o_q = i_d;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Iterative shifter: one bit per cycle, IDLE/SHIFT/DONE handshake FSM with registered outputs.
// Optional macro SHIFT_UNIT_ROTATE_EN enables ROR; without it opcode 11 is a pass-through.
module shift_unit
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   c,
  output logic               zero
);

  state_e             r_state;
  op_e                r_op;
  logic [WIDTH-1:0]   r_work;
  logic [SHAMT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_c;
  logic               r_zero;
  logic               r_out_valid;
  logic               r_in_ready;
  logic [WIDTH-1:0]   w_step;
  logic               w_direct;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_d  (r_work),
    .i_op (r_op),
    .o_q  (w_step)
  );

  // Requests that need no shifting skip SHIFT and present a unchanged.
`ifdef SHIFT_UNIT_ROTATE_EN
  assign w_direct = (shamt == '0);
`else
  assign w_direct = (shamt == '0) || (opcode == OP_ROR);
`endif

  // DONE is entered on the edge where the count reaches zero, carrying the final step result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_SLA;
      r_work      <= '0;
      r_cnt       <= '0;
      r_c         <= '0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            r_op       <= op_e'(opcode);
            r_work     <= a;
            if (w_direct) begin
              r_state     <= ST_DONE;
              r_cnt       <= '0;
              r_c         <= a;
              r_zero      <= (a == '0);
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ST_SHIFT;
              r_cnt   <= shamt;
            end
          end
        end
        ST_SHIFT: begin
          r_work <= w_step;
          r_cnt  <= r_cnt - SHAMT_W'(1);
          if (r_cnt == SHAMT_W'(1)) begin
            r_state     <= ST_DONE;
            r_c         <= w_step;
            r_zero      <= (w_step == '0);
            r_out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_zero      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_zero      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign c         = r_c;
  assign zero      = r_zero;

endmodule

// File: tb/tb_shift_unit.sv
// Directed vector bench for shift_unit (WIDTH=32); ROR expectations follow SHIFT_UNIT_ROTATE_EN.
module tb_shift_unit;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SHAMT_W = 5;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [SHAMT_W-1:0] shamt;
  logic [1:0]         opcode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   c;
  logic               zero;

  int checks;
  int errors;

  shift_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .shamt     (shamt),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [1:0]  op;
    logic [31:0] exp_c;
    logic        exp_zero;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one request, measures edges from accept to out_valid, checks result, then consumes it.
  task automatic run_op(input string name, input logic [31:0] ia, input logic [4:0] ish,
                        input logic [1:0] iop, input logic [31:0] exp_c, input logic exp_z,
                        input int exp_lat);
    int lat;
    chk({name, ".in_ready_pre"}, 64'(in_ready), 64'd1);
    a = ia; shamt = ish; opcode = iop; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 32'hDEAD_BEEF; shamt = 5'd7; opcode = 2'b01;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, ".out_valid"}, 64'(out_valid), 64'd1);
    chk({name, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({name, ".c"}, 64'(c), 64'(exp_c));
    chk({name, ".zero"}, 64'(zero), 64'(exp_z));
    @(posedge clk); #1;
    chk({name, ".consumed"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; shamt = '0; opcode = '0;

    vecs[0]  = '{32'h0000_0001, 5'd4,  2'b00, 32'h0000_0010, 1'b0, 5};
    vecs[1]  = '{32'h8000_0000, 5'd31, 2'b01, 32'hFFFF_FFFF, 1'b0, 32};
    vecs[2]  = '{32'h8000_0000, 5'd31, 2'b10, 32'h0000_0001, 1'b0, 32};
    vecs[3]  = '{32'h1234_5678, 5'd0,  2'b00, 32'h1234_5678, 1'b0, 1};
    vecs[4]  = '{32'h1234_5678, 5'd0,  2'b10, 32'h1234_5678, 1'b0, 1};
    vecs[5]  = '{32'h8000_0000, 5'd1,  2'b00, 32'h0000_0000, 1'b1, 2};
    vecs[6]  = '{32'h7000_0000, 5'd4,  2'b01, 32'h0700_0000, 1'b0, 5};
    vecs[7]  = '{32'hF000_0000, 5'd4,  2'b10, 32'h0F00_0000, 1'b0, 5};
    vecs[8]  = '{32'hFFFF_FFFF, 5'd31, 2'b00, 32'h8000_0000, 1'b0, 32};
    vecs[9]  = '{32'h8000_0000, 5'd0,  2'b01, 32'h8000_0000, 1'b0, 1};
`ifdef SHIFT_UNIT_ROTATE_EN
    vecs[10] = '{32'h0000_0001, 5'd1,  2'b11, 32'h8000_0000, 1'b0, 2};
    vecs[11] = '{32'h1234_5678, 5'd8,  2'b11, 32'h7812_3456, 1'b0, 9};
`else
    vecs[10] = '{32'h0000_0001, 5'd1,  2'b11, 32'h0000_0001, 1'b0, 1};
    vecs[11] = '{32'h1234_5678, 5'd8,  2'b11, 32'h1234_5678, 1'b0, 1};
`endif

    #12;
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.c", 64'(c), 64'd0);
    chk("reset.zero", 64'(zero), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].shamt, vecs[i].op,
             vecs[i].exp_c, vecs[i].exp_zero, vecs[i].exp_lat);
    end

    // Back-pressure: result must hold for 10 cycles while a second request is offered.
    begin
      int lat;
      out_ready = 1'b0;
      a = 32'h0000_0001; shamt = 5'd4; opcode = 2'b00; in_valid = 1'b1;
      @(posedge clk); #1;
      a = 32'hAAAA_5555; shamt = 5'd2; opcode = 2'b10;
      lat = 1;
      while (!out_valid && lat < 200) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("hold.latency", 64'(lat), 64'd5);
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        chk($sformatf("hold.c%0d", k), 64'(c), 64'h10);
        chk($sformatf("hold.valid%0d", k), 64'(out_valid), 64'd1);
        chk($sformatf("hold.in_ready%0d", k), 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("hold.released_valid", 64'(out_valid), 64'd0);
      chk("hold.released_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      chk("hold.no_second_accept", 64'(in_ready), 64'd1);
      chk("hold.c_kept", 64'(c), 64'h10);
    end

    // Asynchronous reset in the middle of a long shift.
    a = 32'h0000_00F0; shamt = 5'd20; opcode = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
    end
    chk("midrst.busy", 64'(in_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("midrst.in_ready", 64'(in_ready), 64'd1);
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    chk("midrst.c", 64'(c), 64'd0);
    chk("midrst.zero", 64'(zero), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 30; k++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      chk("midrst.no_result", 64'(seen), 64'd0);
    end
    run_op("after_rst", 32'h0000_00F0, 5'd20, 2'b00, 32'h0F00_0000, 1'b0, 21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
